// File: rtl/instr_mem_pipe.sv
// Fetch-stage instruction memory: byte-addressed word RAM with a READ_LAT-deep read pipeline,
// an in-order response buffer with backpressure, and a byte-enabled loader write port.
module instr_mem_pipe #(
    parameter int DEPTH_WORDS = 1024,
    parameter int ADDR_W      = 32,
    parameter int READ_LAT    = 1,
    parameter int RSP_DEPTH   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [ADDR_W-1:0] req_addr_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [31:0]       rsp_instr_o,
    output logic              rsp_err_o,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [31:0]       wr_data_i,
    input  logic [3:0]        wr_be_i,
    output logic              wr_err_o
);
    // Handshake: a request transfers on an edge where req_valid_i & req_ready_o, a response
    // leaves on an edge where rsp_valid_o & rsp_ready_i; ready never depends on valid.

    localparam int IDX_W  = $clog2(DEPTH_WORDS);
    localparam int PTR_W  = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CNT_W  = $clog2(RSP_DEPTH + 1);
    localparam int WIDX_W = ADDR_W - 2;

    typedef struct packed {
        logic        vld;
        logic        err;
        logic [31:0] data;
    } slot_t;

    typedef struct packed {
        logic        err;
        logic [31:0] data;
    } rsp_t;

    logic [31:0]      mem_q [DEPTH_WORDS];
    slot_t            pipe_q [READ_LAT];
    slot_t            pipe_d [READ_LAT];
    rsp_t             rbuf_q [RSP_DEPTH];
    rsp_t             rbuf_d [RSP_DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wr_err_q, wr_err_d;

    logic [CNT_W-1:0] pipe_cnt;
    logic [CNT_W:0]   inflight;
    logic             req_acc, req_ok, wr_ok;
    logic             buf_empty, rsp_pop, buf_push, buf_pop;
    slot_t            tail, head;
    logic [IDX_W-1:0] req_idx, wr_idx;

    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return (a[1:0] == 2'b00) && (a[ADDR_W-1:2] < WIDX_W'(DEPTH_WORDS));
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign req_idx = req_addr_i[IDX_W+1:2];
    assign wr_idx  = wr_addr_i[IDX_W+1:2];

    // Outstanding reads include those still travelling the pipeline, so the buffer can never overflow.
    always_comb begin
        pipe_cnt = '0;
        for (int i = 0; i < READ_LAT; i++) begin
            pipe_cnt = pipe_cnt + CNT_W'(pipe_q[i].vld);
        end
        inflight = (CNT_W+1)'(cnt_q) + (CNT_W+1)'(pipe_cnt);
    end

    assign req_ready_o = (inflight < (CNT_W+1)'(RSP_DEPTH));

    always_comb begin
        req_acc = req_valid_i && req_ready_o;
        req_ok  = addr_ok(req_addr_i);

        // RAM is sampled on the accepting edge, so a same-edge write is not yet visible.
        pipe_d[0].vld  = req_acc;
        pipe_d[0].err  = req_acc && !req_ok;
        pipe_d[0].data = (req_acc && req_ok) ? mem_q[req_idx] : 32'h0;
        for (int i = 1; i < READ_LAT; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end

        tail      = pipe_q[READ_LAT-1];
        buf_empty = (cnt_q == '0);

        // An empty buffer exposes the last pipeline stage directly; otherwise its oldest entry.
        head = tail;
        if (!buf_empty) begin
            head.vld  = 1'b1;
            head.err  = rbuf_q[rd_ptr_q].err;
            head.data = rbuf_q[rd_ptr_q].data;
        end

        rsp_pop  = head.vld && rsp_ready_i;
        buf_pop  = rsp_pop && !buf_empty;
        buf_push = tail.vld && !(buf_empty && rsp_pop);

        rbuf_d = rbuf_q;
        if (buf_push) begin
            rbuf_d[wr_ptr_q].err  = tail.err;
            rbuf_d[wr_ptr_q].data = tail.data;
        end
        wr_ptr_d = buf_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = buf_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        cnt_d    = cnt_q + CNT_W'(buf_push) - CNT_W'(buf_pop);

        wr_ok    = wr_en_i && addr_ok(wr_addr_i);
        wr_err_d = wr_en_i && !wr_ok;
    end

    assign rsp_valid_o = head.vld;
    assign rsp_instr_o = head.vld ? head.data : 32'h0;
    assign rsp_err_o   = head.vld && head.err;
    assign wr_err_o    = wr_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < READ_LAT; i++) begin
                pipe_q[i] <= '0;
            end
            for (int i = 0; i < RSP_DEPTH; i++) begin
                rbuf_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            wr_err_q <= 1'b0;
        end else begin
            pipe_q   <= pipe_d;
            rbuf_q   <= rbuf_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
            wr_err_q <= wr_err_d;
        end
    end

    // Storage array keeps its contents across reset.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be_i[b]) begin
                    mem_q[wr_idx][8*b +: 8] <= wr_data_i[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_mem_pipe.sv
// Bench for instr_mem_pipe: unit 0 uses READ_LAT=1, unit 1 uses READ_LAT=3, both RSP_DEPTH=4.
// A queue-based reference model is compared every cycle, plus directed literal checks.
module tb_instr_mem_pipe;
    localparam int DW = 1024;
    localparam int RD = 4;

    typedef struct {
        logic [31:0] d;
        logic        e;
        int          avail;
    } exp_t;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid [2];
    logic        req_ready [2];
    logic [31:0] req_addr  [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [31:0] rsp_instr [2];
    logic        rsp_err   [2];
    logic        wr_en     [2];
    logic [31:0] wr_addr   [2];
    logic [31:0] wr_data   [2];
    logic [3:0]  wr_be     [2];
    logic        wr_err    [2];

    int          n_pass  = 0;
    int          n_total = 0;
    int          cyc     = 0;
    exp_t        exp_q [2][$];
    logic [31:0] mm [2][DW];
    logic        wr_err_m [2];
    logic [31:0] got_q [$];

    always #5 clk = ~clk;

    instr_mem_pipe #(.DEPTH_WORDS(DW), .ADDR_W(32), .READ_LAT(1), .RSP_DEPTH(RD)) dut_l1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]), .req_addr_i(req_addr[0]),
        .rsp_valid_o(rsp_valid[0]), .rsp_ready_i(rsp_ready[0]), .rsp_instr_o(rsp_instr[0]),
        .rsp_err_o(rsp_err[0]), .wr_en_i(wr_en[0]), .wr_addr_i(wr_addr[0]),
        .wr_data_i(wr_data[0]), .wr_be_i(wr_be[0]), .wr_err_o(wr_err[0])
    );

    instr_mem_pipe #(.DEPTH_WORDS(DW), .ADDR_W(32), .READ_LAT(3), .RSP_DEPTH(RD)) dut_l3 (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]), .req_addr_i(req_addr[1]),
        .rsp_valid_o(rsp_valid[1]), .rsp_ready_i(rsp_ready[1]), .rsp_instr_o(rsp_instr[1]),
        .rsp_err_o(rsp_err[1]), .wr_en_i(wr_en[1]), .wr_addr_i(wr_addr[1]),
        .wr_data_i(wr_data[1]), .wr_be_i(wr_be[1]), .wr_err_o(wr_err[1])
    );

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic logic bad_addr(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a[31:2] >= 30'(DW));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", name, act, exp);
    endtask

    // Reference model: every accepted request becomes a queue entry that is due READ_LAT-1
    // cycles after the accepting edge and leaves when the consumer takes it.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                exp_q[i].delete();
                wr_err_m[i] = 1'b0;
            end else begin
                logic acc;
                exp_t ent;
                acc = req_valid[i] && (exp_q[i].size() < RD);
                if (exp_q[i].size() > 0) begin
                    if (cyc >= exp_q[i][0].avail && rsp_ready[i]) void'(exp_q[i].pop_front());
                end
                if (acc) begin
                    ent.e     = bad_addr(req_addr[i]);
                    ent.d     = ent.e ? 32'h0 : mm[i][req_addr[i][11:2]];
                    ent.avail = cyc + lat_of(i);
                    exp_q[i].push_back(ent);
                end
                wr_err_m[i] = wr_en[i] && bad_addr(wr_addr[i]);
                if (wr_en[i] && !bad_addr(wr_addr[i])) begin
                    for (int b = 0; b < 4; b++) begin
                        if (wr_be[i][b]) mm[i][wr_addr[i][11:2]][8*b +: 8] = wr_data[i][8*b +: 8];
                    end
                end
            end
        end
        cyc = cyc + 1;
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            logic        ev;
            logic        ee;
            logic [31:0] ed;
            ev = 1'b0;
            ee = 1'b0;
            ed = 32'h0;
            if (rst_n && exp_q[i].size() > 0) begin
                if (cyc >= exp_q[i][0].avail) begin
                    ev = 1'b1;
                    ee = exp_q[i][0].e;
                    ed = exp_q[i][0].d;
                end
            end
            chk($sformatf("u%0d rsp_valid", i), 32'(rsp_valid[i]), 32'(ev));
            chk($sformatf("u%0d rsp_instr", i), rsp_instr[i], ed);
            chk($sformatf("u%0d rsp_err", i), 32'(rsp_err[i]), 32'(ee));
            chk($sformatf("u%0d req_ready", i), 32'(req_ready[i]),
                32'(!rst_n || (exp_q[i].size() < RD)));
            chk($sformatf("u%0d wr_err", i), 32'(wr_err[i]), 32'(rst_n && wr_err_m[i]));
        end
        if (rst_n && rsp_valid[1] && rsp_ready[1]) got_q.push_back(rsp_instr[1]);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int i, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        wr_en[i]   = 1'b1;
        wr_addr[i] = a;
        wr_data[i] = d;
        wr_be[i]   = be;
        tick();
        wr_en[i] = 1'b0;
    endtask

    task automatic rd_chk(input int i, input logic [31:0] a, input logic [31:0] ed,
                          input logic ee, input string name);
        req_valid[i] = 1'b1;
        req_addr[i]  = a;
        tick();
        req_valid[i] = 1'b0;
        repeat (lat_of(i) - 1) tick();
        @(negedge clk);
        chk({name, " valid"}, 32'(rsp_valid[i]), 32'd1);
        chk({name, " instr"}, rsp_instr[i], ed);
        chk({name, " err"}, 32'(rsp_err[i]), 32'(ee));
        tick();
    endtask

    initial begin
        int   n_acc;
        logic acc;
        for (int i = 0; i < 2; i++) begin
            req_valid[i] = 1'b0;
            req_addr[i]  = 32'h0;
            rsp_ready[i] = 1'b1;
            wr_en[i]     = 1'b0;
            wr_addr[i]   = 32'h0;
            wr_data[i]   = 32'h0;
            wr_be[i]     = 4'h0;
            wr_err_m[i]  = 1'b0;
        end
        repeat (3) tick();
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("reset u%0d ready", i), 32'(req_ready[i]), 32'd1);
            chk($sformatf("reset u%0d valid", i), 32'(rsp_valid[i]), 32'd0);
            chk($sformatf("reset u%0d wr_err", i), 32'(wr_err[i]), 32'd0);
        end
        tick();
        rst_n = 1'b1;
        tick();

        // Basic read, READ_LAT=1
        wr(0, 32'h10, 32'hDEADBEEF, 4'hF);
        rd_chk(0, 32'h10, 32'hDEADBEEF, 1'b0, "t1");

        // Byte enables and the all-zero enable no-op
        wr(0, 32'h20, 32'h11223344, 4'hF);
        wr(0, 32'h20, 32'hAABBCCDD, 4'b0101);
        rd_chk(0, 32'h20, 32'h11BB33DD, 1'b0, "t2 be");
        wr(0, 32'h20, 32'hFFFFFFFF, 4'h0);
        rd_chk(0, 32'h20, 32'h11BB33DD, 1'b0, "t2 be0");

        // Misaligned / out-of-range reads and writes
        wr(0, 32'h0, 32'hCAFEF00D, 4'hF);
        rd_chk(0, 32'h6, 32'h0, 1'b1, "t4 mis");
        rd_chk(0, 32'h1000, 32'h0, 1'b1, "t4 oor");
        wr(0, 32'h1000, 32'h0BADBAD0, 4'hF);
        @(negedge clk);
        chk("t4 wr_err pulse", 32'(wr_err[0]), 32'd1);
        tick();
        @(negedge clk);
        chk("t4 wr_err clear", 32'(wr_err[0]), 32'd0);
        tick();
        wr(0, 32'h2, 32'h0BADBAD0, 4'hF);
        rd_chk(0, 32'h0, 32'hCAFEF00D, 1'b0, "t4 word0");

        // Same-edge write and read of one word: read sees the old value
        wr(0, 32'h40, 32'h7, 4'hF);
        wr_en[0]     = 1'b1;
        wr_addr[0]   = 32'h40;
        wr_data[0]   = 32'h5;
        wr_be[0]     = 4'hF;
        req_valid[0] = 1'b1;
        req_addr[0]  = 32'h40;
        tick();
        wr_en[0]     = 1'b0;
        req_valid[0] = 1'b0;
        @(negedge clk);
        chk("t5 old valid", 32'(rsp_valid[0]), 32'd1);
        chk("t5 old instr", rsp_instr[0], 32'h7);
        tick();
        rd_chk(0, 32'h40, 32'h5, 1'b0, "t5 new");

        // Backpressure with READ_LAT=3, RSP_DEPTH=4
        for (int j = 0; j < 6; j++) wr(1, 32'h100 + 32'(4*j), 32'hA0000000 + 32'(j), 4'hF);
        got_q.delete();
        rsp_ready[1] = 1'b0;
        req_valid[1] = 1'b1;
        req_addr[1]  = 32'h100;
        n_acc        = 0;
        repeat (8) begin
            @(negedge clk);
            acc = req_ready[1];
            tick();
            if (acc) begin
                n_acc++;
                req_addr[1] = req_addr[1] + 32'd4;
            end
        end
        chk("t3 accepted while stalled", 32'(n_acc), 32'd4);
        @(negedge clk);
        chk("t3 ready low", 32'(req_ready[1]), 32'd0);
        chk("t3 head valid", 32'(rsp_valid[1]), 32'd1);
        chk("t3 head instr", rsp_instr[1], 32'hA0000000);
        tick();
        rsp_ready[1] = 1'b1;
        for (int c = 0; c < 30 && n_acc < 6; c++) begin
            @(negedge clk);
            acc = req_ready[1];
            tick();
            if (acc) begin
                n_acc++;
                req_addr[1] = req_addr[1] + 32'd4;
            end
            if (n_acc == 6) req_valid[1] = 1'b0;
        end
        req_valid[1] = 1'b0;
        chk("t3 accepted total", 32'(n_acc), 32'd6);
        for (int c = 0; c < 40 && got_q.size() < 6; c++) tick();
        chk("t3 rsp count", 32'(got_q.size()), 32'd6);
        for (int j = 0; j < 6; j++) begin
            chk($sformatf("t3 rsp%0d", j), (j < got_q.size()) ? got_q[j] : 32'hFFFFFFFF,
                32'hA0000000 + 32'(j));
        end

        // Reset with reads in flight
        wr(1, 32'h8, 32'h12345678, 4'hF);
        tick();
        got_q.delete();
        req_valid[1] = 1'b1;
        req_addr[1]  = 32'h8;
        repeat (3) tick();
        req_valid[1] = 1'b0;
        chk("t6 valid before reset", 32'(rsp_valid[1]), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t6 valid in reset", 32'(rsp_valid[1]), 32'd0);
        chk("t6 instr in reset", rsp_instr[1], 32'h0);
        chk("t6 ready in reset", 32'(req_ready[1]), 32'd1);
        tick();
        tick();
        rst_n = 1'b1;
        repeat (8) tick();
        chk("t6 no stale rsp", 32'(got_q.size()), 32'd0);
        rd_chk(1, 32'h8, 32'h12345678, 1'b0, "t6 ram1");
        rd_chk(0, 32'h10, 32'hDEADBEEF, 1'b0, "t6 ram0");

        repeat (3) tick();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
